ceespu_mem_arbiter: RTL

Shares one single-port synchronous RAM (1-cycle read latency, byte write enables) between three requesters: the ceespu instruction fetch, the ceespu data port, and a debug/loader port. It sits between the core and the memory, and generates a core stall whenever a core request is not granted. It also supports an exclusive debug lock for multi-cycle debug bursts.

---
 rtl/ceespu_mem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ceespu_mem_arbiter.sv
// Three-way arbiter (debug > data > fetch) for one single-port RAM, with debug lock.
// Optional fetch anti-starvation boost: define CEESPU_ARB_FAIRNESS_EN.
module ceespu_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_ifReq,
  input  logic [ADDR_W-1:0] I_ifAddr,
  output logic              O_ifGnt,
  output logic              O_ifValid,
  output logic [31:0]       O_ifData,
  input  logic              I_dReq,
  input  logic [ADDR_W-1:0] I_dAddr,
  input  logic [3:0]        I_dWe,
  input  logic [31:0]       I_dWData,
  output logic              O_dGnt,
  output logic              O_dValid,
  output logic [31:0]       O_dData,
  input  logic              I_dbgReq,
  input  logic              I_dbgLock,
  input  logic [ADDR_W-1:0] I_dbgAddr,
  input  logic [3:0]        I_dbgWe,
  input  logic [31:0]       I_dbgWData,
  output logic              O_dbgGnt,
  output logic              O_dbgValid,
  output logic [31:0]       O_dbgData,
  output logic              O_memE,
  output logic [3:0]        O_memWe,
  output logic [ADDR_W-1:0] O_memAddr,
  output logic [31:0]       O_memWData,
  input  logic [31:0]       I_memData,
  output logic              O_stall
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be 1..15");
  end

  typedef enum logic {FREE, LOCKED} lock_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D, OWN_DBG} own_e;

  lock_e lockState_q;
  own_e  owner_q, owner_d;
  logic  ownerRd_q, ownerRd_d;
  logic  fetchBoost;

`ifdef CEESPU_ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starveCnt_q, starveCnt_d;

  assign fetchBoost = (lockState_q == FREE) && (starveCnt_q >= LIMIT);

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (O_ifGnt || !I_ifReq)
      starveCnt_d = '0;
    else if (lockState_q == FREE && starveCnt_q != 4'hF)
      starveCnt_d = starveCnt_q + 4'd1;
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) starveCnt_q <= '0;
    else       starveCnt_q <= starveCnt_d;
  end
`else
  assign fetchBoost = 1'b0;
`endif

  always_comb begin
    O_ifGnt  = 1'b0;
    O_dGnt   = 1'b0;
    O_dbgGnt = 1'b0;
    if (!I_rst) begin
      if (lockState_q == LOCKED)       O_dbgGnt = I_dbgReq;
      else if (fetchBoost && I_ifReq)  O_ifGnt  = 1'b1;
      else if (I_dbgReq)               O_dbgGnt = 1'b1;
      else if (I_dReq)                 O_dGnt   = 1'b1;
      else if (I_ifReq)                O_ifGnt  = 1'b1;
    end
  end

  always_comb begin
    O_memWe    = '0;
    O_memAddr  = '0;
    O_memWData = '0;
    owner_d    = OWN_NONE;
    unique case (1'b1)
      O_dbgGnt: begin
        O_memWe    = I_dbgWe;
        O_memAddr  = I_dbgAddr;
        O_memWData = I_dbgWData;
        owner_d    = OWN_DBG;
      end
      O_dGnt: begin
        O_memWe    = I_dWe;
        O_memAddr  = I_dAddr;
        O_memWData = I_dWData;
        owner_d    = OWN_D;
      end
      O_ifGnt: begin
        O_memAddr  = I_ifAddr;
        owner_d    = OWN_IF;
      end
      default: ;
    endcase
  end

  assign O_memE    = O_ifGnt | O_dGnt | O_dbgGnt;
  assign ownerRd_d = O_memE && (O_memWe == 4'h0);
  assign O_stall   = (I_ifReq & ~O_ifGnt) | (I_dReq & ~O_dGnt);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      lockState_q <= FREE;
      owner_q     <= OWN_NONE;
      ownerRd_q   <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      ownerRd_q <= ownerRd_d;
      if (lockState_q == FREE && O_dbgGnt && I_dbgLock)
        lockState_q <= LOCKED;
      else if (lockState_q == LOCKED && !I_dbgLock)
        lockState_q <= FREE;
    end
  end

  assign O_ifValid  = (owner_q == OWN_IF)  && ownerRd_q;
  assign O_dValid   = (owner_q == OWN_D)   && ownerRd_q;
  assign O_dbgValid = (owner_q == OWN_DBG) && ownerRd_q;
  assign O_ifData   = I_memData;
  assign O_dData    = I_memData;
  assign O_dbgData  = I_memData;

endmodule
